// File: rtl/coverfloat_pkg.sv
// Shared constants, vector layout and helpers for the coverage collector front end.
package coverfloat_pkg;

  localparam int COVER_VECTOR_WIDTH = 801;
  localparam int COVER_VEC_NWORDS   = 26;
  localparam int COVER_VEC_PAD_W    = 32 * COVER_VEC_NWORDS - COVER_VECTOR_WIDTH;

  // Rounding modes
  localparam logic [7:0] ROUND_NEAR_EVEN   = 8'h00;
  localparam logic [7:0] ROUND_MINMAG      = 8'h01;
  localparam logic [7:0] ROUND_MIN         = 8'h02;
  localparam logic [7:0] ROUND_MAX         = 8'h03;
  localparam logic [7:0] ROUND_NEAR_MAXMAG = 8'h04;
  localparam logic [7:0] ROUND_ODD         = 8'h05;

  // Format codes
  localparam logic [7:0] FMT_HALF   = 8'h00;
  localparam logic [7:0] FMT_SINGLE = 8'h01;
  localparam logic [7:0] FMT_DOUBLE = 8'h02;
  localparam logic [7:0] FMT_QUAD   = 8'h03;
  localparam logic [7:0] FMT_BF16   = 8'h04;
  localparam logic [7:0] FMT_INT    = 8'h81;
  localparam logic [7:0] FMT_UINT   = 8'hC1;
  localparam logic [7:0] FMT_LONG   = 8'h82;
  localparam logic [7:0] FMT_ULONG  = 8'hC2;
  localparam logic [7:0] FMT_INVAL  = 8'hFF;

  // Field LSB offsets inside the packed vector
  localparam int OFF_OP       = 769;
  localparam int OFF_RM       = 761;
  localparam int OFF_A        = 633;
  localparam int OFF_B        = 505;
  localparam int OFF_C        = 377;
  localparam int OFF_OP_FMT   = 369;
  localparam int OFF_RES      = 241;
  localparam int OFF_RES_FMT  = 233;
  localparam int OFF_INT_SIGN = 232;
  localparam int OFF_INT_EXP  = 200;
  localparam int OFF_INT_SIG  = 8;
  localparam int OFF_FLAGS    = 0;

  // First member lands at the MSB end of the 801-bit vector
  typedef struct packed {
    logic [31:0]  op;
    logic [7:0]   rm;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [7:0]   op_fmt;
    logic [127:0] res;
    logic [7:0]   res_fmt;
    logic         int_sign;
    logic [31:0]  int_exp;
    logic [191:0] int_sig;
    logic [7:0]   flags;
  } cover_vec_t;

  typedef enum logic [0:0] {IDLE, COLLECT} asm_state_t;

  function automatic logic fmt_is_legal(input logic [7:0] fmt);
    case (fmt)
      FMT_HALF, FMT_SINGLE, FMT_DOUBLE, FMT_QUAD, FMT_BF16,
      FMT_INT, FMT_UINT, FMT_LONG, FMT_ULONG, FMT_INVAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/coverfloat_vector_assembler_if.sv
// Word-stream input and unpacked-vector output bundle of the assembler.
interface coverfloat_vector_assembler_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_op;
  logic [7:0]   out_rm;
  logic [127:0] out_a;
  logic [127:0] out_b;
  logic [127:0] out_c;
  logic [7:0]   out_op_fmt;
  logic [127:0] out_res;
  logic [7:0]   out_res_fmt;
  logic         out_int_sign;
  logic [31:0]  out_int_exp;
  logic [191:0] out_int_sig;
  logic [7:0]   out_flags;
  logic         out_err;
  logic         err_sticky;
  logic [31:0]  vec_count;

  // Assembler side
  modport master (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c, out_op_fmt,
           out_res, out_res_fmt, out_int_sign, out_int_exp, out_int_sig, out_flags,
           out_err, err_sticky, vec_count
  );

  // Word source and coverpoint sampler side
  modport slave (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c, out_op_fmt,
           out_res, out_res_fmt, out_int_sign, out_int_exp, out_int_sig, out_flags,
           out_err, err_sticky, vec_count
  );
endinterface

// File: rtl/coverfloat_vec_check.sv
// Combinational malformed-vector detector: padding, rounding mode and format codes.
module coverfloat_vec_check
  import coverfloat_pkg::*;
(
  input  cover_vec_t                 vec_i,
  input  logic [COVER_VEC_PAD_W-1:0] pad_i,
  output logic                       err_o
);

  // Payload fields carry no legality information
  logic unused_payload;
  assign unused_payload = ^{vec_i.op, vec_i.a, vec_i.b, vec_i.c, vec_i.res, vec_i.int_sign,
                            vec_i.int_exp, vec_i.int_sig, vec_i.flags};

  // Any single violation marks the whole vector malformed
  always_comb begin
    err_o = 1'b0;
    if (|pad_i)                       err_o = 1'b1;
    if (vec_i.rm > ROUND_ODD)         err_o = 1'b1;
    if (!fmt_is_legal(vec_i.op_fmt))  err_o = 1'b1;
    if (!fmt_is_legal(vec_i.res_fmt)) err_o = 1'b1;
  end

endmodule

// File: rtl/coverfloat_vector_assembler.sv
// Reassembles 26-word streams into 801-bit coverage vectors and presents
// the unpacked fields through a one-entry valid/ready output register.
module coverfloat_vector_assembler
  import coverfloat_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int VEC_W  = COVER_VECTOR_WIDTH,
  parameter int NWORDS = COVER_VEC_NWORDS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  coverfloat_vector_assembler_if.master bus
);

  localparam int          BUF_W = (NWORDS - 1) * WORD_W;
  localparam logic [4:0]  LAST  = 5'(NWORDS - 1);

  asm_state_t        state_q, state_d;
  logic [4:0]        wcnt_q, wcnt_d;
  logic [WORD_W-1:0] slice_q [NWORDS-1];
  logic [BUF_W-1:0]  asm_vec;
  cover_vec_t        full_vec;
  cover_vec_t        vec_q;
  logic              out_valid_q, out_err_q, err_sticky_q;
  logic [31:0]       vec_count_q;
  logic              accept, drain, transfer, chk_err;

  // Only the final word can stall, and only while the held vector is not draining
  assign bus.in_ready = !((wcnt_q == LAST) && out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign drain        = out_valid_q && bus.out_ready;

  // Words 0..24 are buffered; word 25 bypasses straight into the output register
  generate
    for (genvar gi = 0; gi < NWORDS - 1; gi++) begin : g_flatten
      assign asm_vec[gi*WORD_W +: WORD_W] = slice_q[gi];
    end
  endgenerate

  assign full_vec = cover_vec_t'({bus.in_word[0], asm_vec[VEC_W-2:0]});

  coverfloat_vec_check u_check (
    .vec_i (full_vec),
    .pad_i (bus.in_word[WORD_W-1:1]),
    .err_o (chk_err)
  );

  // Collector state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Collector next state; flush wins over any word offered in the same cycle
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    transfer = 1'b0;
    if (flush) begin
      state_d = IDLE;
      wcnt_d  = 5'd0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          state_d = COLLECT;
          wcnt_d  = 5'd1;
        end
        COLLECT: begin
          if (wcnt_q == LAST) begin
            state_d  = IDLE;
            wcnt_d   = 5'd0;
            transfer = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 5'd1;
          end
        end
        default: begin
          state_d = IDLE;
          wcnt_d  = 5'd0;
        end
      endcase
    end
  end

  // Word buffer; stale contents are harmless since every slice is rewritten per vector
  always_ff @(posedge clk) begin
    if (!reset && accept && (wcnt_q != LAST)) begin
      slice_q[wcnt_q] <= bus.in_word;
    end
  end

  // Output register, error flags and delivery counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      vec_count_q  <= 32'd0;
      vec_q        <= '0;
    end else begin
      if (transfer) begin
        out_valid_q  <= 1'b1;
        vec_q        <= full_vec;
        out_err_q    <= chk_err;
        err_sticky_q <= err_sticky_q | chk_err;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (drain) begin
        vec_count_q <= vec_count_q + 32'd1;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_err      = out_err_q;
  assign bus.err_sticky   = err_sticky_q;
  assign bus.vec_count    = vec_count_q;
  assign bus.out_op       = vec_q.op;
  assign bus.out_rm       = vec_q.rm;
  assign bus.out_a        = vec_q.a;
  assign bus.out_b        = vec_q.b;
  assign bus.out_c        = vec_q.c;
  assign bus.out_op_fmt   = vec_q.op_fmt;
  assign bus.out_res      = vec_q.res;
  assign bus.out_res_fmt  = vec_q.res_fmt;
  assign bus.out_int_sign = vec_q.int_sign;
  assign bus.out_int_exp  = vec_q.int_exp;
  assign bus.out_int_sig  = vec_q.int_sig;
  assign bus.out_flags    = vec_q.flags;

endmodule

// File: doc/coverfloat_vector_assembler.md
# coverfloat_vector_assembler

Front-end stage of the floating-point coverage collector. It receives coverage vectors as a stream of 32-bit words from the testbench vector source (file reader / DPI) and reassembles each 801-bit vector. It unpacks every vector into named fields and presents them with a valid/ready handshake to the coverpoint sampling stage. Partial-vector assembly overlaps with a held output, so the source is stalled only on the final word of a vector.

## Interface

Parameters:
- `WORD_W`, 32, input word width; only 32 is supported.
- `VEC_W`, `` `COVER_VECTOR_WIDTH `` (801), packed vector width.
- `NWORDS`, 26, words per vector (ceil(801/32)).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: sync abort of any partially collected vector; the output register is untouched.
- `in_valid` in 1, `in_ready` out 1, `in_word` in 32: input word stream.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_op` out 32: operation code.
- `out_rm` out 8: rounding mode.
- `out_a`, `out_b`, `out_c` out 128 each: source operands.
- `out_op_fmt` out 8: operand format.
- `out_res` out 128: result.
- `out_res_fmt` out 8: result format.
- `out_int_sign` out 1, `out_int_exp` out 32, `out_int_sig` out 192: unrounded intermediate result.
- `out_flags` out 8: exception flags.
- `out_err` out 1: current output vector is malformed.
- `err_sticky` out 1: any malformed vector since reset.
- `vec_count` out 32: vectors delivered (out handshakes).

## Operation

Vector packing, MSB to LSB:
- op[800:769], rm[768:761], a[760:633], b[632:505], c[504:377], op_fmt[376:369], res[368:241], res_fmt[240:233], int_sign[232], int_exp[231:200], int_sig[199:8], flags[7:0].

Word order:
- Word k carries vector bits [32k+31:32k]. Word 0 is sent first.
- Word 25 bits [31:1] are padding (vector bits 831:801).

Collector FSM (states IDLE, COLLECT):
- IDLE -> COLLECT on accepting word 0; `wcnt` becomes 1.
- COLLECT: each accepted word is written at slice `wcnt` and `wcnt` increments.
- Accepting word 25 transfers the assembled vector into the output register and returns the FSM to IDLE with `wcnt`=0.

Output register:
- One entry. `out_valid` sets on transfer and clears on out handshake.
- Fields are combinational slices of the held vector.

`in_ready` rules:
- `in_ready` = 1 unless `wcnt`==25 and `out_valid` && !`out_ready`.
- On the final word, a simultaneous drain and refill is allowed in the same cycle.

Malformed-vector check (`out_err`), set at transfer when any of:
- the padding bits are nonzero;
- rm > 5 (ROUND_ODD);
- op_fmt or res_fmt is not one of HALF, SINGLE, DOUBLE, QUAD, BF16, INT, UINT, LONG, ULONG, INVAL.

A malformed vector is still delivered. `err_sticky` sets with it and stays set until reset.

`flush`:
- Clears `wcnt` to 0 and the FSM to IDLE; any word presented that cycle is dropped.
- `flush` has priority over `in_valid`.

`vec_count`:
- Increments on each out handshake and wraps at 2^32.

Reset:
- FSM IDLE, `wcnt` 0, `out_valid` 0, `out_err` 0, `err_sticky` 0, `vec_count` 0, vector register 0.
- All field outputs read 0 after reset.
- `in_ready` is 1 in the cycle after reset deasserts.

## Timing

- Full-throughput input: 1 word per cycle.
- `out_valid` rises the cycle after word 25 is accepted.
- Sustained throughput is 1 vector per 26 cycles with no bubbles, provided the consumer drains within 25 cycles.
- Reset asserted mid-vector discards the partial vector and any held output. No handshake completes in a reset cycle.
- Outputs are registered. `in_ready` depends combinationally on `out_ready` only in the `wcnt`==25 case.

## Structure

- Add to `coverfloat_pkg`:
  - `COVER_VEC_NWORDS` = 26;
  - a packed struct `cover_vec_t` giving the field layout above;
  - the field-offset localparams;
  - a `fmt_is_legal()` function over the FMT_* constants.
- The rm bound uses the existing ROUND_ODD constant.
- Sub-module `coverfloat_vec_check`: combinational legality check producing `err` from a `cover_vec_t`.
- The collector FSM and output register stay in the top module.

## Test plan

- Single vector, op=32'h10, rm=0, a=32'h3f800000, b=32'h40000000, legal fmts, padding 0, 26 back-to-back words, `out_ready`=1 -> `out_valid` the cycle after word 25 with exact field values, `out_err`=0, `vec_count`=1.
- Two vectors back-to-back with `out_ready`=0 until cycle 60 -> `in_ready` drops only when word 25 of vector 2 is presented. Releasing `out_ready` drains vector 1, and vector 2 loads that same cycle with no lost word.
- Word 25 = 32'h2 (padding nonzero) -> vector delivered with `out_err`=1 and `err_sticky`=1. A following legal vector gives `out_err`=0 while `err_sticky` stays 1.
- rm=8'd6, and separately op_fmt=8'h05 -> `out_err`=1 in each case.
- `flush` after word 10, then a full vector -> the output matches only the second vector; `vec_count` increments by 1.
- `reset` asserted at word 13 with an output held -> `out_valid`=0, `vec_count`=0, `in_ready`=1 the next cycle; a fresh vector assembles correctly.
